junction_gather_sequencer: RTL and testbench

Drives the cycle_index of one junction's DRP interleaver set and consumes the memory_index_package it returns. Each clock it selects z activations from the p-wide activation bank and registers them as one beat for the z processing lanes. The output uses a valid/ready handshake, and junction start/done is controlled by start/busy/done. One instance sits between each layer's activation storage and its interleaver_set / lane datapath.

---
 rtl/junction_gather_sequencer.sv | 176 +++++++++++++++++
 tb/tb_junction_gather_sequencer.sv | 479 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/junction_gather_sequencer.sv
// -----------------------------------------------------------------------------
// junction_gather_sequencer
//
// Purpose:
//   Steps one junction's DRP interleaver set through its CPC cycles. Each
//   cycle the counter drives cycle_index to the interleaver set. The returned
//   memory_index_package picks z activations out of the p-wide activation
//   bank. Those z activations are registered as one beat for the z processing
//   lanes. Beats leave through a valid/ready handshake. A junction is framed
//   by start / busy / done.
//
// Optional feature (compile-time macro JGS_BACK_TO_BACK_EN):
//   When defined, a start seen in DRAIN in the same cycle the last beat is
//   accepted launches the next junction directly (DRAIN -> RUN). IDLE is
//   skipped. When undefined, that start is ignored.
//
// Ports:
//   clk                  in   clock
//   reset                in   synchronous active-high reset (highest priority)
//   start                in   start-junction pulse, sampled in IDLE
//   act_in               in   activation bank; neuron k at [n*k +: n]
//   cycle_index          out  current interleaver cycle (straight from counter)
//   memory_index_package in   per-lane neuron index; slot s at [IW*s +: IW]
//   act_out              out  gathered beat; slot s at [n*s +: n]
//   act_valid            out  act_out holds a beat
//   act_ready            in   consumer accepts the beat this cycle
//   act_cycle            out  cycle_index that produced act_out
//   act_last             out  act_out is the final beat of the junction
//   busy                 out  state is RUN or DRAIN
//   done                 out  one-cycle pulse after the last beat is accepted
//
// Handshake: a beat transfers on a rising clk edge where act_valid and
// act_ready are both high. act_out, act_cycle and act_last hold steady while
// act_valid is high and act_ready is low. act_valid never drops without a
// transfer, except on reset.
// -----------------------------------------------------------------------------
module junction_gather_sequencer #(
    parameter int fo = 2,
    parameter int p  = 16,
    parameter int n  = 8,
    parameter int z  = 8,
    localparam int CPC = fo * p / z,
    localparam int CW  = $clog2(CPC),
    localparam int IW  = $clog2(p)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [p*n-1:0]    act_in,
    output logic [CW-1:0]     cycle_index,
    input  logic [IW*z-1:0]   memory_index_package,
    output logic [z*n-1:0]    act_out,
    output logic              act_valid,
    input  logic              act_ready,
    output logic [CW-1:0]     act_cycle,
    output logic              act_last,
    output logic              busy,
    output logic              done
);

    // Elaboration guards: the junction must split evenly over the lanes.
    // The cycle count must also be a power of two, so the counter wraps
    // naturally.
    if ((fo * p) % z != 0) begin : g_bad_split
        $error("junction_gather_sequencer: fo*p must be divisible by z");
    end
    if (CPC < 2 || (CPC & (CPC - 1)) != 0) begin : g_bad_cpc
        $error("junction_gather_sequencer: fo*p/z must be a power of 2 and >= 2");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    // state_q is kept as a named enum register so checkers can bind to it.
    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [z*n-1:0]   act_out_q;
    logic             act_valid_q;
    logic [CW-1:0]    act_cycle_q;
    logic             act_last_q;
    logic             done_q;

    logic [z*n-1:0]   gather_d;
    logic [IW-1:0]    idx;
    logic             adv;
    logic             last_cnt;

    // Gather: the interleaver returns its indices combinationally for the
    // current cycle_index, so the mux result is ready in the same cycle.
    // The result is registered only once.
    always_comb begin
        gather_d = '0;
        idx      = '0;
        for (int s = 0; s < z; s++) begin
            idx                 = memory_index_package[IW*s +: IW];
            gather_d[n*s +: n]  = act_in[n*idx +: n];
        end
    end

    // A new beat may be captured when the output register is empty or is
    // being emptied this same cycle. This gives full throughput.
    assign adv      = (state_q == S_RUN) && (!act_valid_q || act_ready);
    assign last_cnt = (cnt_q == CW'(CPC - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            act_out_q   <= '0;
            act_valid_q <= 1'b0;
            act_cycle_q <= '0;
            act_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (start) begin
                        state_q <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (adv) begin
                        act_out_q   <= gather_d;
                        act_valid_q <= 1'b1;
                        act_cycle_q <= cnt_q;
                        act_last_q  <= last_cnt;
                        if (last_cnt) begin
                            cnt_q   <= '0;
                            state_q <= S_DRAIN;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end

                S_DRAIN: begin
                    // Only the final beat is left in the output register.
                    if (act_valid_q && act_ready) begin
                        act_valid_q <= 1'b0;
                        act_last_q  <= 1'b0;
                        done_q      <= 1'b1;
`ifdef JGS_BACK_TO_BACK_EN
                        // Counter is already 0 from the wrap in RUN.
                        if (start) begin
                            state_q <= S_RUN;
                        end else begin
                            state_q <= S_IDLE;
                        end
`else
                        state_q <= S_IDLE;
`endif
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cycle_index = cnt_q;
    assign act_out     = act_out_q;
    assign act_valid   = act_valid_q;
    assign act_cycle   = act_cycle_q;
    assign act_last    = act_last_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;

endmodule

// File: tb/tb_junction_gather_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for junction_gather_sequencer (fo=2, p=16, n=8, z=8 -> CPC=4).
// The interleaver is modelled by a stub. It returns slot s = (2*s + cycle) % 16.
// Expected beats come from the bench's own reference model. That model
// gathers bank[(2*s + c) % 16] for each cycle c of a junction.
// -----------------------------------------------------------------------------
module tb_junction_gather_sequencer;

    localparam int FO  = 2;
    localparam int P   = 16;
    localparam int N   = 8;
    localparam int Z   = 8;
    localparam int CPC = 4;
    localparam int CW  = 2;
    localparam int IW  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [P*N-1:0]    act_in;
    logic [CW-1:0]     cycle_index;
    logic [IW*Z-1:0]   mip;
    logic [Z*N-1:0]    act_out;
    logic              act_valid;
    logic              act_ready;
    logic [CW-1:0]     act_cycle;
    logic              act_last;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;

    logic [Z*N-1:0] exp_q[$];
    logic [7:0]     bank[P];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    junction_gather_sequencer #(.fo(FO), .p(P), .n(N), .z(Z)) dut (
        .clk                  (clk),
        .reset                (reset),
        .start                (start),
        .act_in               (act_in),
        .cycle_index          (cycle_index),
        .memory_index_package (mip),
        .act_out              (act_out),
        .act_valid            (act_valid),
        .act_ready            (act_ready),
        .act_cycle            (act_cycle),
        .act_last             (act_last),
        .busy                 (busy),
        .done                 (done)
    );

    // Interleaver stub.
    always_comb begin
        mip = '0;
        for (int s = 0; s < Z; s++) begin
            mip[IW*s +: IW] = IW'((2 * s + int'(cycle_index)) % P);
        end
    end

    // Global watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks / model ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_bank();
        for (int k = 0; k < P; k++) act_in[N*k +: N] = bank[k];
    endtask

    task automatic ramp_bank();
        for (int k = 0; k < P; k++) bank[k] = 8'(8'hA0 + k);
        load_bank();
    endtask

    function automatic logic [Z*N-1:0] model_beat(input int c);
        logic [Z*N-1:0] r;
        r = '0;
        for (int s = 0; s < Z; s++) r[N*s +: N] = bank[(2 * s + c) % P];
        return r;
    endfunction

    task automatic push_junction();
        for (int c = 0; c < CPC; c++) exp_q.push_back(model_beat(c));
    endtask

    // Pulse start for one edge; returns just after that edge (edge T).
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; start = 1'b0; act_ready = 1'b0;
        act_in = '0;
        tick(); tick();
        checks++;
        if (act_out !== '0 || act_valid !== 1'b0 || act_cycle !== '0 ||
            act_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cycle_index !== '0) begin
            errors++;
            $display("FAIL reset_state: out=%h v=%b cyc=%0d last=%b busy=%b done=%b ci=%0d required all 0",
                     act_out, act_valid, act_cycle, act_last, busy, done, cycle_index);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [Z*N-1:0] e;
        ramp_bank();
        act_ready = 1'b1;
        exp_q.delete();
        push_junction();
        pulse_start();
        for (int j = 1; j <= 6; j++) begin
            tick();
            if (j <= 4) begin
                e = exp_q.pop_front();
                checks++;
                if (act_valid !== 1'b1 || act_cycle !== CW'(j - 1) || act_last !== (j == 4) || act_out !== e) begin
                    errors++;
                    $display("FAIL basic_beat%0d: v=%b cyc=%0d last=%b out=%h required v=1 cyc=%0d last=%0d out=%h",
                             j - 1, act_valid, act_cycle, act_last, act_out, j - 1, (j == 4), e);
                end
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_busy j=%0d: busy=%b required 1", j, busy);
                end
                if (j == 1) begin
                    checks++;
                    if (act_out[3*N +: N] !== 8'hA6 || act_out[7*N +: N] !== 8'hAE) begin
                        errors++;
                        $display("FAIL basic_beat0_slots: slot3=%h slot7=%h required A6 AE",
                                 act_out[3*N +: N], act_out[7*N +: N]);
                    end
                end
                if (j == 4) begin
                    checks++;
                    if (act_out[7*N +: N] !== 8'hA1) begin
                        errors++;
                        $display("FAIL basic_beat3_slot7: got %h required A1", act_out[7*N +: N]);
                    end
                end
            end
            checks++;
            if (done !== (j == 5)) begin
                errors++;
                $display("FAIL basic_done j=%0d: done=%b required %0d", j, done, (j == 5));
            end
            if (j == 5) begin
                checks++;
                if (act_valid !== 1'b0 || act_last !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_drained: v=%b last=%b required 0 0", act_valid, act_last);
                end
            end
            if (j == 6) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_busy_fall: busy=%b required 0", busy);
                end
            end
        end
    endtask

    task automatic test_stall();
        int stalls = 0;
        int beats = 0;
        int done_j = -1;
        logic [Z*N-1:0] e;
        ramp_bank();
        act_ready = 1'b1;
        exp_q.delete();
        push_junction();
        pulse_start();
        for (int j = 1; j <= 14; j++) begin
            tick();
            if (done) begin
                checks++;
                if (done_j != -1 || beats != 4) begin
                    errors++;
                    $display("FAIL stall_done_once: j=%0d prev=%0d beats=%0d required single done after 4 beats",
                             j, done_j, beats);
                end
                done_j = j;
            end
            if (act_valid && act_cycle == CW'(1) && stalls < 3) begin
                act_ready = 1'b0;
                stalls++;
                checks++;
                if (act_out !== model_beat(1) || cycle_index !== CW'(2)) begin
                    errors++;
                    $display("FAIL stall_hold: out=%h ci=%0d required %h ci=2",
                             act_out, cycle_index, model_beat(1));
                end
            end else begin
                act_ready = 1'b1;
            end
            if (act_valid && act_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stall_extra_beat: cyc=%0d required no beat", act_cycle);
                end else begin
                    e = exp_q.pop_front();
                    if (act_out !== e || act_cycle !== CW'(beats) || act_last !== (beats == 3)) begin
                        errors++;
                        $display("FAIL stall_beat%0d: out=%h cyc=%0d last=%b required %h cyc=%0d last=%0d",
                                 beats, act_out, act_cycle, act_last, e, beats, (beats == 3));
                    end
                end
                beats++;
            end
        end
        act_ready = 1'b1;
        checks++;
        if (done_j != 8 || beats != 4 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_summary: done_at=%0d beats=%0d left=%0d required 8 4 0",
                     done_j, beats, exp_q.size());
        end
    endtask

    task automatic test_start_in_run();
        int beats = 0;
        int dones = 0;
        logic [Z*N-1:0] e;
        ramp_bank();
        act_ready = 1'b1;
        exp_q.delete();
        push_junction();
        pulse_start();
        for (int j = 1; j <= 12; j++) begin
            tick();
            if (done) dones++;
            start = (act_valid && act_cycle == CW'(1));
            if (act_valid) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                checks++;
                if (act_out !== e || act_cycle !== CW'(beats)) begin
                    errors++;
                    $display("FAIL start_run_beat%0d: out=%h cyc=%0d required %h cyc=%0d",
                             beats, act_out, act_cycle, e, beats);
                end
                beats++;
            end
        end
        start = 1'b0;
        checks++;
        if (beats != 4 || dones != 1 || busy !== 1'b0 || act_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_run_ignored: beats=%0d dones=%0d busy=%b v=%b required 4 1 0 0",
                     beats, dones, busy, act_valid);
        end
    endtask

    task automatic test_reset_mid();
        int beats = 0;
        int dones = 0;
        bit hit = 0;
        logic [Z*N-1:0] e;
        ramp_bank();
        act_ready = 1'b1;
        pulse_start();
        for (int j = 0; j < 10 && !hit; j++) begin
            tick();
            if (act_valid && act_cycle == CW'(2)) hit = 1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL reset_mid_reach: act_cycle 2 never seen within budget");
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (act_out !== '0 || act_valid !== 1'b0 || act_cycle !== '0 || act_last !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || cycle_index !== '0) begin
            errors++;
            $display("FAIL reset_mid_state: out=%h v=%b cyc=%0d last=%b busy=%b done=%b ci=%0d required all 0",
                     act_out, act_valid, act_cycle, act_last, busy, done, cycle_index);
        end
        exp_q.delete();
        push_junction();
        pulse_start();
        for (int j = 1; j <= 6; j++) begin
            tick();
            if (done) dones++;
            if (act_valid) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                checks++;
                if (act_out !== e || act_cycle !== CW'(beats)) begin
                    errors++;
                    $display("FAIL reset_mid_beat%0d: out=%h cyc=%0d required %h cyc=%0d",
                             beats, act_out, act_cycle, e, beats);
                end
                beats++;
            end
        end
        checks++;
        if (beats != 4 || dones != 1) begin
            errors++;
            $display("FAIL reset_mid_rerun: beats=%0d dones=%0d required 4 1", beats, dones);
        end
    endtask

    task automatic test_coverage();
        int hits[P];
        int v;
        for (int k = 0; k < P; k++) hits[k] = 0;
        ramp_bank();
        act_ready = 1'b1;
        pulse_start();
        for (int j = 1; j <= 5; j++) begin
            tick();
            if (act_valid) begin
                for (int s = 0; s < Z; s++) begin
                    v = int'(act_out[N*s +: N]) - 'hA0;
                    if (v >= 0 && v < P) hits[v]++;
                end
            end
        end
        for (int k = 0; k < P; k++) begin
            checks++;
            if (hits[k] != FO) begin
                errors++;
                $display("FAIL coverage_neuron%0d: selected %0d times required %0d", k, hits[k], FO);
            end
        end
        tick();
    endtask

    task automatic test_random();
        logic [Z*N-1:0] e;
        for (int r = 0; r < 6; r++) begin
            int beats = 0;
            int dones = 0;
            for (int k = 0; k < P; k++) bank[k] = 8'($urandom_range(0, 255));
            load_bank();
            exp_q.delete();
            push_junction();
            act_ready = 1'($urandom_range(0, 1));
            pulse_start();
            for (int j = 0; j < 80 && dones == 0; j++) begin
                tick();
                if (done) dones++;
                act_ready = ($urandom_range(0, 3) != 0);
                if (act_valid && act_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL random%0d_extra: unexpected beat cyc=%0d", r, act_cycle);
                    end else begin
                        e = exp_q.pop_front();
                        if (act_out !== e || act_cycle !== CW'(beats) || act_last !== (beats == CPC - 1)) begin
                            errors++;
                            $display("FAIL random%0d_beat%0d: out=%h cyc=%0d last=%b required %h cyc=%0d last=%0d",
                                     r, beats, act_out, act_cycle, act_last, e, beats, (beats == CPC - 1));
                        end
                    end
                    beats++;
                end
            end
            checks++;
            if (dones != 1 || beats != CPC || exp_q.size() != 0) begin
                errors++;
                $display("FAIL random%0d_summary: dones=%0d beats=%0d left=%0d required 1 4 0",
                         r, dones, beats, exp_q.size());
            end
            act_ready = 1'b1;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        bit hit = 0;
        ramp_bank();
        act_ready = 1'b1;
        pulse_start();
        for (int j = 0; j < 10 && !hit; j++) begin
            tick();
            if (act_valid && act_last) hit = 1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL b2b_last: last beat never seen within budget");
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || act_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done: done=%b v=%b required 1 0", done, act_valid);
        end
`ifdef JGS_BACK_TO_BACK_EN
        begin
            int dones = 0;
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL b2b_busy_gap: busy=%b required 1", busy);
            end
            tick();
            checks++;
            if (act_valid !== 1'b1 || act_cycle !== CW'(0) || act_out !== model_beat(0) || busy !== 1'b1) begin
                errors++;
                $display("FAIL b2b_second_beat0: v=%b cyc=%0d out=%h busy=%b required 1 0 %h 1",
                         act_valid, act_cycle, act_out, busy, model_beat(0));
            end
            for (int j = 0; j < 8 && dones == 0; j++) begin
                tick();
                if (done) dones++;
                else begin
                    checks++;
                    if (busy !== 1'b1) begin
                        errors++;
                        $display("FAIL b2b_busy_run: busy=%b required 1", busy);
                    end
                end
            end
            checks++;
            if (dones != 1) begin
                errors++;
                $display("FAIL b2b_second_done: dones=%0d required 1", dones);
            end
        end
`else
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: busy=%b required 0", busy);
        end
        for (int j = 0; j < 5; j++) begin
            tick();
            checks++;
            if (act_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL b2b_no_second: v=%b busy=%b done=%b required 0 0 0", act_valid, busy, done);
            end
        end
`endif
        tick();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_basic();
        tick();
        test_stall();
        tick();
        test_start_in_run();
        test_reset_mid();
        tick();
        test_coverage();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
